whack_round_engine: RTL and testbench
=====================================

Name: whack_round_engine

Overview:
Parametrised game-round controller for the whack-a-box game. It sits between the sensor decoder (box address), the LFSR, and the display/audio blocks. It owns target selection, strike detection, hit/miss scoring, per-target timeout with difficulty ramp, the countdown game timer, and sound triggers. It generalises the fixed 3-bit, untimed hit logic to N boxes, timed windows, penalties and a proper game FSM.

Parameters:
NUM_BOXES, 7, boxes are numbered 1..NUM_BOXES; 0 means "no box"
BOX_W, 3, width of box addresses; must satisfy 2^BOX_W > NUM_BOXES
SCORE_W, 11, score width
CLK_HZ, 50000000, clock cycles per game-timer second
GAME_SECONDS, 60, game length in seconds
TARGET_CYCLES, 50000000, level-0 target window in cycles
HITS_PER_LEVEL, 5, consecutive-hit count that advances the level
MAX_LEVEL, 3, highest level; window = TARGET_CYCLES >> level
SOUND_CYCLES, 5000000, length of play_sound/miss_sound pulses
MISS_PENALTY, 1, enables the 1-point decrement on a wrong-box strike (0 disables)

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
start_game  in  1  level; sampled in LOBBY/OVER
box_address  in  BOX_W  struck box from the sensor decoder; 0 = none
lfsr_value  in  BOX_W  free-running random value
target_box  out  BOX_W  currently lit box; 0 when no target is shown
score  out  SCORE_W  current score
game_timer  out  $clog2(GAME_SECONDS+1)  seconds remaining
level  out  $clog2(MAX_LEVEL+1)  difficulty level
game_over  out  1  high in OVER
lobby_sound  out  1  high in LOBBY
play_sound  out  1  hit pulse, SOUND_CYCLES long
miss_sound  out  1  wrong-strike pulse, SOUND_CYCLES long

Behaviour:
- Reset (synchronous; also mid-game) forces LOBBY. Output values: target_box=0, score=0, game_timer=GAME_SECONDS, level=0, game_over=0, lobby_sound=1, play_sound=0, miss_sound=0. Reset also clears all counters and the strike history.
- Strike detection: box_address is registered twice (box_q, box_q2). strike = box_q!=0 && box_q!=box_q2. A held box counts once. Score changes on the edge after strike is seen, which is 2 cycles after the input changes.
- FSM:
  - LOBBY: lobby_sound=1. On start_game: score=0, level=0, game_timer=GAME_SECONDS, second prescaler cleared; go to ARM.
  - ARM: accept lfsr_value only if it is in 1..NUM_BOXES and differs from the previous target; otherwise stay and retry next cycle. On accept: latch target_box, load the window counter with TARGET_CYCLES>>level, go to SHOW.
  - SHOW:
    - strike==target: score+1, saturating at 2^SCORE_W-1; play_sound pulse; hit streak+1. When the streak reaches HITS_PER_LEVEL, level+1 (saturating at MAX_LEVEL) and the streak is cleared. target_box=0; go to ARM.
    - strike!=target: if MISS_PENALTY, score-1 with a floor at 0; miss_sound pulse; streak cleared; stay in SHOW. The window counter is not reloaded.
    - Window counter reaches 0: no score change; streak cleared; target_box=0; go to ARM.
  - OVER: game_over=1, target_box=0, score held. start_game behaves as in LOBBY (restart).
- Game timer: prescaler counts CLK_HZ cycles in ARM/SHOW and decrements game_timer on wrap. When game_timer reaches 0, go to OVER on the next edge. The timer is frozen in LOBBY/OVER.
- Simultaneous events:
  - Hit and timer expiry in the same cycle: the hit is scored, then OVER.
  - Hit and window expiry in the same cycle: the hit wins.
- Sound pulses: a new trigger during an active pulse restarts the SOUND_CYCLES count. play_sound and miss_sound cannot both start in the same cycle.
- Window width is $clog2(TARGET_CYCLES+1); the shift amount is level.

Decomposition:
- Package whack_pkg holds:
  - state enum (LOBBY, ARM, SHOW, OVER)
  - BOX_W and SCORE_W defaults
  - the NO_BOX=0 constant
- Sub-module sec_tick_gen (parameter CLK_HZ) provides the prescaler. Its inputs are clear and enable; its output is a one-cycle tick.

Test Plan:
All scenarios use CLK_HZ=4, GAME_SECONDS=3, TARGET_CYCLES=16, HITS_PER_LEVEL=2, MAX_LEVEL=2, SOUND_CYCLES=2.
1. Reset, then start_game, lfsr_value=3 -> target_box=3 within 2 cycles. Drive box_address=3 -> score=1 two cycles later; play_sound high for 2 cycles; target_box=0.
2. Target=5, drive box_address=2 held for 10 cycles -> score decrements once (floored at 0 from 0); miss_sound pulses once; state stays SHOW.
3. Two consecutive hits -> level=1; the next window is 8 cycles. With no strike, target_box clears after 8 cycles and score is unchanged.
4. lfsr_value sequence 0, 7 (>NUM_BOXES is not applicable, so use 9 with BOX_W=4), then previous target, then 4 -> ARM rejects the first three; target_box=4.
5. No strikes for 12 cycles -> game_timer 3→0, then game_over=1. A hit landing on the expiry cycle is still scored.
6. Assert reset during SHOW with score=2 -> next cycle: LOBBY, score=0, lobby_sound=1, all pulses low.

Source files
------------

// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-box round engine.
package whack_pkg;

  typedef enum logic [1:0] {
    StLobby,
    StArm,
    StShow,
    StOver
  } state_e;

  localparam int unsigned BOX_W_DEFAULT   = 3;
  localparam int unsigned SCORE_W_DEFAULT = 11;
  localparam int unsigned NO_BOX          = 0;

endpackage

// File: rtl/sec_tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_HZ enabled cycles.
module sec_tick_gen #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CntW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_HZ - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == CntMax) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/whack_round_engine.sv
// Game-round controller: target selection, strike scoring, target windows with
// difficulty ramp, countdown game timer and sound pulses.
module whack_round_engine
  import whack_pkg::*;
#(
  parameter int unsigned NUM_BOXES      = 7,
  parameter int unsigned BOX_W          = BOX_W_DEFAULT,
  parameter int unsigned SCORE_W        = SCORE_W_DEFAULT,
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned GAME_SECONDS   = 60,
  parameter int unsigned TARGET_CYCLES  = 50000000,
  parameter int unsigned HITS_PER_LEVEL = 5,
  parameter int unsigned MAX_LEVEL      = 3,
  parameter int unsigned SOUND_CYCLES   = 5000000,
  parameter int unsigned MISS_PENALTY   = 1,
  localparam int unsigned TimerW = $clog2(GAME_SECONDS + 1),
  localparam int unsigned LevelW = $clog2(MAX_LEVEL + 1)
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start_game,
  input  logic [BOX_W-1:0]   box_address,
  input  logic [BOX_W-1:0]   lfsr_value,
  output logic [BOX_W-1:0]   target_box,
  output logic [SCORE_W-1:0] score,
  output logic [TimerW-1:0]  game_timer,
  output logic [LevelW-1:0]  level,
  output logic               game_over,
  output logic               lobby_sound,
  output logic               play_sound,
  output logic               miss_sound
);

  localparam int unsigned WinW    = $clog2(TARGET_CYCLES + 1);
  localparam int unsigned StreakW = $clog2(HITS_PER_LEVEL + 1);
  localparam int unsigned SndW    = $clog2(SOUND_CYCLES + 1);

  localparam logic [SCORE_W-1:0] ScoreMax  = '1;
  localparam logic [TimerW-1:0]  TimerInit = TimerW'(GAME_SECONDS);
  localparam logic [LevelW-1:0]  LevelMax  = LevelW'(MAX_LEVEL);
  localparam logic [StreakW-1:0] StreakTop = StreakW'(HITS_PER_LEVEL);
  localparam logic [WinW-1:0]    WinBase   = WinW'(TARGET_CYCLES);
  localparam logic [WinW-1:0]    WinOne    = WinW'(1);
  localparam logic [SndW-1:0]    SndLoad   = SndW'(SOUND_CYCLES);
  localparam logic [BOX_W-1:0]   BoxMax    = BOX_W'(NUM_BOXES);
  localparam logic [BOX_W-1:0]   NoBox     = BOX_W'(NO_BOX);

  state_e             state_q, state_d;
  logic [BOX_W-1:0]   box_q, box_q2;
  logic [BOX_W-1:0]   target_q, target_d, prev_q, prev_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LevelW-1:0]  level_q, level_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [WinW-1:0]    win_q, win_d;
  logic [SndW-1:0]    play_q, play_d, miss_q, miss_d;

  logic strike, hit, wrong, lfsr_ok, playing, tick, tick_clear, tick_en;

  // A held box shows up once: only a change to a non-zero address is a strike.
  assign strike  = (box_q != NoBox) && (box_q != box_q2);
  assign hit     = (state_q == StShow) && strike && (box_q == target_q);
  assign wrong   = (state_q == StShow) && strike && (box_q != target_q);
  assign lfsr_ok = (lfsr_value != NoBox) && (lfsr_value <= BoxMax) && (lfsr_value != prev_q);

  assign playing    = (state_q == StArm) || (state_q == StShow);
  assign tick_en    = playing && (timer_q != '0);
  assign tick_clear = ((state_q == StLobby) || (state_q == StOver)) && start_game;

  sec_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_tick (
    .clk   (CLOCK_50),
    .reset (reset),
    .clear (tick_clear),
    .enable(tick_en),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    prev_d   = prev_q;
    score_d  = score_q;
    level_d  = level_q;
    streak_d = streak_q;
    timer_d  = timer_q;
    win_d    = win_q;
    play_d   = (play_q != '0) ? play_q - 1'b1 : play_q;
    miss_d   = (miss_q != '0) ? miss_q - 1'b1 : miss_q;

    unique case (state_q)
      StLobby, StOver: begin
        if (start_game) begin
          score_d  = '0;
          level_d  = '0;
          streak_d = '0;
          timer_d  = TimerInit;
          target_d = NoBox;
          state_d  = StArm;
        end
      end
      StArm: begin
        if (lfsr_ok) begin
          target_d = lfsr_value;
          prev_d   = lfsr_value;
          win_d    = WinBase >> level_q;
          state_d  = StShow;
        end
      end
      StShow: begin
        if (hit) begin
          if (score_q != ScoreMax) score_d = score_q + 1'b1;
          play_d = SndLoad;
          if (streak_q + 1'b1 == StreakTop) begin
            streak_d = '0;
            if (level_q != LevelMax) level_d = level_q + 1'b1;
          end else begin
            streak_d = streak_q + 1'b1;
          end
          target_d = NoBox;
          state_d  = StArm;
        end else begin
          if (wrong) begin
            if ((MISS_PENALTY != 0) && (score_q != '0)) score_d = score_q - 1'b1;
            miss_d   = SndLoad;
            streak_d = '0;
          end
          if (win_q <= WinOne) begin
            streak_d = '0;
            target_d = NoBox;
            state_d  = StArm;
          end else begin
            win_d = win_q - 1'b1;
          end
        end
      end
      default: state_d = StLobby;
    endcase

    if (tick) timer_d = timer_q - 1'b1;
    // Timer expiry overrides any ARM/SHOW transition; a same-cycle hit is already scored.
    if (playing && (timer_q == '0)) begin
      state_d  = StOver;
      target_d = NoBox;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= StLobby;
      box_q    <= NoBox;
      box_q2   <= NoBox;
      target_q <= NoBox;
      prev_q   <= NoBox;
      score_q  <= '0;
      level_q  <= '0;
      streak_q <= '0;
      timer_q  <= TimerInit;
      win_q    <= '0;
      play_q   <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      box_q    <= box_address;
      box_q2   <= box_q;
      target_q <= target_d;
      prev_q   <= prev_d;
      score_q  <= score_d;
      level_q  <= level_d;
      streak_q <= streak_d;
      timer_q  <= timer_d;
      win_q    <= win_d;
      play_q   <= play_d;
      miss_q   <= miss_d;
    end
  end

  assign target_box  = target_q;
  assign score       = score_q;
  assign game_timer  = timer_q;
  assign level       = level_q;
  assign game_over   = (state_q == StOver);
  assign lobby_sound = (state_q == StLobby);
  assign play_sound  = (play_q != '0);
  assign miss_sound  = (miss_q != '0);

endmodule

// File: tb/tb_whack_round_engine.sv
// Directed scoreboard bench for whack_round_engine; a second instance with a
// slower prescaler gives a game long enough to observe a full level-1 window.
module tb_whack_round_engine;

  localparam int BW = 4;
  localparam int SW = 11;

  localparam int S_TGT = 0, S_SCORE = 1, S_TIMER = 2, S_LEVEL = 3, S_OVER = 4;
  localparam int S_LOBBY = 5, S_PLAY = 6, S_MISS = 7;
  localparam int S2_TGT = 8, S2_SCORE = 9, S2_LEVEL = 10;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b1;
  logic          start_game = 1'b0;
  logic [BW-1:0] box_address = '0;
  logic [BW-1:0] lfsr_value = '0;

  logic [BW-1:0] target_box, target_box2;
  logic [SW-1:0] score, score2;
  logic [1:0]    game_timer, game_timer2, level, level2;
  logic          game_over, lobby_sound, play_sound, miss_sound;
  logic          game_over2, lobby_sound2, play_sound2, miss_sound2;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  whack_round_engine #(
    .NUM_BOXES(7), .BOX_W(BW), .SCORE_W(SW), .CLK_HZ(4), .GAME_SECONDS(3),
    .TARGET_CYCLES(16), .HITS_PER_LEVEL(2), .MAX_LEVEL(2), .SOUND_CYCLES(2), .MISS_PENALTY(1)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start_game(start_game),
    .box_address(box_address), .lfsr_value(lfsr_value),
    .target_box(target_box), .score(score), .game_timer(game_timer), .level(level),
    .game_over(game_over), .lobby_sound(lobby_sound), .play_sound(play_sound),
    .miss_sound(miss_sound)
  );

  whack_round_engine #(
    .NUM_BOXES(7), .BOX_W(BW), .SCORE_W(SW), .CLK_HZ(16), .GAME_SECONDS(3),
    .TARGET_CYCLES(16), .HITS_PER_LEVEL(2), .MAX_LEVEL(2), .SOUND_CYCLES(2), .MISS_PENALTY(1)
  ) dut_long (
    .CLOCK_50(CLOCK_50), .reset(reset), .start_game(start_game),
    .box_address(box_address), .lfsr_value(lfsr_value),
    .target_box(target_box2), .score(score2), .game_timer(game_timer2), .level(level2),
    .game_over(game_over2), .lobby_sound(lobby_sound2), .play_sound(play_sound2),
    .miss_sound(miss_sound2)
  );

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_TGT:    return 32'(target_box);
      S_SCORE:  return 32'(score);
      S_TIMER:  return 32'(game_timer);
      S_LEVEL:  return 32'(level);
      S_OVER:   return 32'(game_over);
      S_LOBBY:  return 32'(lobby_sound);
      S_PLAY:   return 32'(play_sound);
      S_MISS:   return 32'(miss_sound);
      S2_TGT:   return 32'(target_box2);
      S2_SCORE: return 32'(score2);
      S2_LEVEL: return 32'(level2);
      default:  return 'x;
    endcase
  endfunction

  task automatic want(input string tag, input int sel, input int val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = 32'(val);
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.val)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, o, e.val);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start_game = 1'b0;
    box_address = '0;
    step(1);
    reset = 1'b0;
  endtask

  // Start a game and let ARM pick lfsr: ARM after one edge, SHOW after two.
  task automatic start(input int lfsr);
    lfsr_value = BW'(lfsr);
    start_game = 1'b1;
    step(1);
    start_game = 1'b0;
    step(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset();
    want("rst_target", S_TGT, 0);
    want("rst_score", S_SCORE, 0);
    want("rst_timer", S_TIMER, 3);
    want("rst_level", S_LEVEL, 0);
    want("rst_over", S_OVER, 0);
    want("rst_lobby", S_LOBBY, 1);
    want("rst_play", S_PLAY, 0);
    want("rst_miss", S_MISS, 0);
    want("rst_level_long", S2_LEVEL, 0);
    check();

    // Scenario 1: hit, play pulse, then a wrong strike takes score 1 -> 0
    lfsr_value = 3;
    start_game = 1'b1;
    step(1);
    start_game = 1'b0;
    want("arm_lobby_off", S_LOBBY, 0);
    want("arm_no_target", S_TGT, 0);
    check();
    step(1);
    want("s1_target", S_TGT, 3);
    check();
    box_address = 3;
    step(2);
    want("s1_hit_score", S_SCORE, 1);
    want("s1_play_on", S_PLAY, 1);
    want("s1_target_clr", S_TGT, 0);
    check();
    lfsr_value = 6;
    step(1);
    want("s1_play_hold", S_PLAY, 1);
    want("s1_target6", S_TGT, 6);
    check();
    box_address = 2;
    step(1);
    want("s1_play_end", S_PLAY, 0);
    check();
    step(1);
    want("s1_miss_score", S_SCORE, 0);
    want("s1_miss_on", S_MISS, 1);
    want("s1_miss_stay", S_TGT, 6);
    check();

    // Scenario 2: held wrong box penalises once, floored at zero
    do_reset();
    start(5);
    box_address = 2;
    step(2);
    want("s2_floor", S_SCORE, 0);
    want("s2_miss_on", S_MISS, 1);
    want("s2_target", S_TGT, 5);
    check();
    step(2);
    want("s2_miss_end", S_MISS, 0);
    check();
    step(6);
    want("s2_held_miss", S_MISS, 0);
    want("s2_held_score", S_SCORE, 0);
    want("s2_still_show", S_TGT, 5);
    want("s2_timer", S_TIMER, 1);
    check();

    // Scenario 3: two hits raise the level; level-1 window is 8 cycles
    do_reset();
    start(3);
    box_address = 3;
    step(2);
    lfsr_value = 5;
    step(1);
    box_address = 5;
    step(2);
    want("s3_level", S2_LEVEL, 1);
    want("s3_score", S2_SCORE, 2);
    want("s3_level_main", S_LEVEL, 1);
    check();
    lfsr_value = 1;
    step(1);
    want("s3_target", S2_TGT, 1);
    check();
    step(7);
    want("s3_win_last", S2_TGT, 1);
    check();
    step(1);
    want("s3_win_expired", S2_TGT, 0);
    want("s3_score_kept", S2_SCORE, 2);
    want("s3_level_kept", S2_LEVEL, 1);
    check();

    // Scenario 4: ARM rejects 0, out-of-range and repeat values
    do_reset();
    start(2);
    box_address = 2;
    step(2);
    lfsr_value = 0;
    step(1);
    want("s4_rej_zero", S_TGT, 0);
    check();
    lfsr_value = 9;
    step(1);
    want("s4_rej_range", S_TGT, 0);
    check();
    lfsr_value = 2;
    step(1);
    want("s4_rej_repeat", S_TGT, 0);
    check();
    lfsr_value = 4;
    step(1);
    want("s4_accept", S_TGT, 4);
    check();

    // Scenario 5: countdown, hit on the expiry cycle, OVER, restart
    do_reset();
    start(3);
    step(2);
    want("s5_timer3", S_TIMER, 3);
    check();
    step(1);
    want("s5_timer2", S_TIMER, 2);
    check();
    step(4);
    want("s5_timer1", S_TIMER, 1);
    check();
    step(3);
    box_address = 3;
    step(1);
    want("s5_timer0", S_TIMER, 0);
    want("s5_not_over", S_OVER, 0);
    want("s5_pre_score", S_SCORE, 0);
    check();
    step(1);
    want("s5_last_hit", S_SCORE, 1);
    want("s5_over", S_OVER, 1);
    want("s5_over_tgt", S_TGT, 0);
    want("s5_last_play", S_PLAY, 1);
    check();
    step(1);
    want("s5_held_score", S_SCORE, 1);
    want("s5_frozen", S_TIMER, 0);
    want("s5_still_over", S_OVER, 1);
    check();
    lfsr_value = 6;
    start_game = 1'b1;
    step(1);
    start_game = 1'b0;
    want("s5_restart_score", S_SCORE, 0);
    want("s5_restart_timer", S_TIMER, 3);
    want("s5_restart_over", S_OVER, 0);
    check();

    // Scenario 6: reset during SHOW with score 2
    do_reset();
    start(3);
    box_address = 3;
    step(2);
    lfsr_value = 5;
    step(1);
    box_address = 5;
    step(2);
    lfsr_value = 1;
    step(1);
    want("s6_pre_score", S_SCORE, 2);
    want("s6_pre_target", S_TGT, 1);
    check();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    want("s6_score", S_SCORE, 0);
    want("s6_lobby", S_LOBBY, 1);
    want("s6_target", S_TGT, 0);
    want("s6_level", S_LEVEL, 0);
    want("s6_timer", S_TIMER, 3);
    want("s6_play", S_PLAY, 0);
    want("s6_miss", S_MISS, 0);
    want("s6_over", S_OVER, 0);
    check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
